// File: rtl/sign_extend_if.sv
// ---------------------------------------------------------------------------
// sign_extend_if
//   Bundles the immediate-extension request and result signals of the
//   sign_extend unit.
//
//   sign_ex_in   [IN_W]   immediate to extend
//   mode         [2]      00 sext half, 01 zext half, 10 sext byte, 11 zext byte
//   shift2       [1]      scale result by 4 (branch offset)
//   in_valid     [1]      qualifies the request for the registered copy
//   sign_ex_out  [OUT_W]  combinational extended result
//   ext_q        [OUT_W]  registered extended result
//   ext_q_valid  [1]      registered valid
//
//   master : requester side (drives the request, observes results)
//   slave  : the extension unit
// ---------------------------------------------------------------------------
interface sign_extend_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
);
   logic [IN_W-1:0]  sign_ex_in;
   logic [1:0]       mode;
   logic             shift2;
   logic             in_valid;
   logic [OUT_W-1:0] sign_ex_out;
   logic [OUT_W-1:0] ext_q;
   logic             ext_q_valid;

   modport master (
      output sign_ex_in,
      output mode,
      output shift2,
      output in_valid,
      input  sign_ex_out,
      input  ext_q,
      input  ext_q_valid
   );

   modport slave (
      input  sign_ex_in,
      input  mode,
      input  shift2,
      input  in_valid,
      output sign_ex_out,
      output ext_q,
      output ext_q_valid
   );
endinterface

// File: rtl/sign_extend.sv
// ---------------------------------------------------------------------------
// sign_extend
//   Immediate-extension unit for the MIPS datapath. Widens a 16-bit
//   immediate to 32 bits using one of four extension modes, optionally
//   scaling by 4 for branch offsets.
//
//   clk    : rising-edge clock for the registered copy
//   rst_n  : asynchronous active-low reset (clears the registered copy only)
//   bus    : sign_extend_if.slave
//              sign_ex_in/mode/shift2/in_valid in,
//              sign_ex_out (combinational), ext_q/ext_q_valid (1-cycle) out
// ---------------------------------------------------------------------------
module sign_extend #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   sign_extend_if.slave bus
);

   localparam int BYTE_W = 8;

   // Extend the immediate according to the selected mode. Byte modes take
   // only the low byte; the upper input byte is ignored.
   function automatic logic signed [OUT_W-1:0] ext_imm(
      input logic [IN_W-1:0] imm,
      input logic [1:0]      sel
   );
      logic signed [OUT_W-1:0] r;
      r = '0;
      case (sel)
         2'b00: r = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
         2'b01: r = {{(OUT_W-IN_W){1'b0}}, imm};
         2'b10: r = {{(OUT_W-BYTE_W){imm[BYTE_W-1]}}, imm[BYTE_W-1:0]};
         2'b11: r = {{(OUT_W-BYTE_W){1'b0}}, imm[BYTE_W-1:0]};
      endcase
      return r;
   endfunction

   // Word-to-byte address scaling; the two bits shifted out of the top are
   // deliberately discarded.
   function automatic logic signed [OUT_W-1:0] scale4(
      input logic signed [OUT_W-1:0] e
   );
      return {e[OUT_W-3:0], 2'b00};
   endfunction

   logic signed [OUT_W-1:0] w_ext_p0;
   logic signed [OUT_W-1:0] w_res_p0;

   logic        [OUT_W-1:0] r_ext_p1;
   logic                    r_vld_p1;

   // ---- stage p0: combinational extension --------------------------------
   always_comb begin
      w_ext_p0 = ext_imm(bus.sign_ex_in, bus.mode);
      w_res_p0 = bus.shift2 ? scale4(w_ext_p0) : w_ext_p0;
   end

   assign bus.sign_ex_out = w_res_p0;

   // ---- stage p1: registered copy for ID/EX ------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1 <= 1'b0;
         r_ext_p1 <= '0;
      end else begin
         r_vld_p1 <= bus.in_valid;
         if (bus.in_valid) begin
            r_ext_p1 <= w_res_p0;
         end
      end
   end

   assign bus.ext_q       = r_ext_p1;
   assign bus.ext_q_valid = r_vld_p1;

endmodule

// File: tb/tb_sign_extend.sv
// ---------------------------------------------------------------------------
// tb_sign_extend
//   Directed and randomized bench for sign_extend against an arithmetic
//   reference model of the extension rules.
// ---------------------------------------------------------------------------
module tb_sign_extend;

   logic clk;
   logic rst_n;

   sign_extend_if #(.IN_W(16), .OUT_W(32)) bus ();

   sign_extend #(.IN_W(16), .OUT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q;
   logic        exp_v;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%08h want=%08h", tag, got, want);
      end
   endtask

   // Reference: interpret the immediate as a number, extend by value, scale
   // by multiplication and keep the low 32 bits.
   function automatic logic [31:0] model(input logic [15:0] v, input logic [1:0] m, input logic s);
      longint x;
      longint u;
      u = longint'(v);
      case (m)
         2'd0: x = (u >= 32768) ? u - 65536 : u;
         2'd1: x = u;
         2'd2: x = ((u % 256) >= 128) ? (u % 256) - 256 : (u % 256);
         default: x = u % 256;
      endcase
      if (s) x = x * 4;
      return x[31:0];
   endfunction

   // Apply one request, check the combinational result, then check the
   // registered copy after the next rising edge.
   task automatic step(input logic [15:0] v, input logic [1:0] m, input logic s,
                       input logic vl, input logic [31:0] want_comb, input string tag);
      @(negedge clk);
      bus.sign_ex_in = v;
      bus.mode       = m;
      bus.shift2     = s;
      bus.in_valid   = vl;
      #1;
      chk({tag, "_comb"}, bus.sign_ex_out, want_comb);
      @(posedge clk);
      if (rst_n) begin
         exp_v = vl;
         if (vl) exp_q = model(v, m, s);
      end
      #1;
      chk({tag, "_q"}, bus.ext_q, exp_q);
      chk({tag, "_qv"}, {31'b0, bus.ext_q_valid}, {31'b0, exp_v});
   endtask

   initial begin
      logic [15:0] rv;
      logic [1:0]  rm;
      logic        rs;
      logic        rvl;

      rst_n          = 1'b0;
      bus.sign_ex_in = 16'h1234;
      bus.mode       = 2'b00;
      bus.shift2     = 1'b0;
      bus.in_valid   = 1'b1;
      exp_q          = 32'h0;
      exp_v          = 1'b0;

      #3;
      chk("rst_q", bus.ext_q, 32'h0);
      chk("rst_qv", {31'b0, bus.ext_q_valid}, 32'h0);
      chk("rst_comb", bus.sign_ex_out, 32'h0000_1234);
      @(posedge clk); #1;
      chk("rst_hold_q", bus.ext_q, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      step(16'hAAAA, 2'b00, 1'b0, 1'b1, 32'hFFFF_AAAA, "sx_aaaa");
      step(16'h5555, 2'b00, 1'b0, 1'b1, 32'h0000_5555, "sx_5555");
      step(16'h0000, 2'b00, 1'b0, 1'b1, 32'h0000_0000, "sx_0000");
      step(16'hFFFF, 2'b00, 1'b0, 1'b1, 32'hFFFF_FFFF, "sx_ffff");
      step(16'h00FF, 2'b00, 1'b0, 1'b1, 32'h0000_00FF, "sx_00ff");
      step(16'hFF00, 2'b00, 1'b0, 1'b1, 32'hFFFF_FF00, "sx_ff00");
      step(16'h8000, 2'b00, 1'b0, 1'b1, 32'hFFFF_8000, "sx_8000");
      step(16'h7FFF, 2'b00, 1'b0, 1'b1, 32'h0000_7FFF, "sx_7fff");
      step(16'hFF00, 2'b01, 1'b0, 1'b1, 32'h0000_FF00, "zx_ff00");
      step(16'h00FF, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFF, "sb_00ff");
      step(16'h0080, 2'b10, 1'b0, 1'b1, 32'hFFFF_FF80, "sb_0080");
      step(16'hFF80, 2'b11, 1'b0, 1'b1, 32'h0000_0080, "zb_ff80");
      step(16'hFFFF, 2'b00, 1'b1, 1'b1, 32'hFFFF_FFFC, "sh_ffff");
      step(16'h4000, 2'b00, 1'b1, 1'b1, 32'h0001_0000, "sh_4000");
      step(16'h8000, 2'b00, 1'b1, 1'b1, 32'hFFFE_0000, "sh_8000");

      // Registered path: valid then idle (ext_q must hold)
      step(16'h8001, 2'b00, 1'b0, 1'b1, 32'hFFFF_8001, "reg_v1");
      chk("reg_v1_abs", bus.ext_q, 32'hFFFF_8001);
      step(16'h0003, 2'b01, 1'b0, 1'b0, 32'h0000_0003, "reg_v0");
      chk("reg_hold_abs", bus.ext_q, 32'hFFFF_8001);

      // Asynchronous reset between edges
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q = 32'h0;
      exp_v = 1'b0;
      chk("arst_q", bus.ext_q, 32'h0);
      chk("arst_qv", {31'b0, bus.ext_q_valid}, 32'h0);
      bus.sign_ex_in = 16'h00F0;
      bus.mode       = 2'b10;
      bus.shift2     = 1'b1;
      bus.in_valid   = 1'b1;
      #1;
      chk("arst_comb", bus.sign_ex_out, 32'hFFFF_FFC0);
      @(posedge clk); #1;
      chk("arst_hold_q", bus.ext_q, 32'h0);
      chk("arst_hold_qv", {31'b0, bus.ext_q_valid}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      step(16'h1357, 2'b00, 1'b0, 1'b1, 32'h0000_1357, "post_rst");

      // Back-to-back valid, then randomized traffic with mixed valid
      for (int i = 0; i < 40; i++) begin
         rv = 16'($urandom);
         rm = 2'($urandom);
         rs = 1'($urandom);
         step(rv, rm, rs, 1'b1, model(rv, rm, rs), "b2b");
      end
      for (int i = 0; i < 200; i++) begin
         rv  = 16'($urandom);
         rm  = 2'($urandom);
         rs  = 1'($urandom);
         rvl = ($urandom_range(0, 3) != 0);
         step(rv, rm, rs, rvl, model(rv, rm, rs), "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always ends on its own
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $finish;
   end

endmodule

// File: doc/sign_extend.md
Name: sign_extend

Overview:
- Immediate-extension unit for the MIPS datapath; widens a 16-bit instruction immediate to 32 bits.
- Provides a combinational result for single-cycle use.
- Also provides a registered, valid-qualified copy for the pipelined ID/EX path.
- Supports sign extension, zero extension, byte-source extension and branch-offset scaling (<<2).

Parameters:
- IN_W, 16, width of immediate input (fixed 16 in this revision).
- OUT_W, 32, width of extended output (fixed 32 in this revision).

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst_n  input  1  asynchronous active-low reset.
- sign_ex_in  input  16  immediate to extend.
- mode  input  2  extension mode: 00 sign-extend halfword, 01 zero-extend halfword, 10 sign-extend low byte, 11 zero-extend low byte.
- shift2  input  1  1 = result shifted left by 2 (branch offset), low two bits zero.
- in_valid  input  1  qualifies sign_ex_in/mode/shift2 for the registered path.
- sign_ex_out  output  32  combinational extended result.
- ext_q  output  32  registered extended result.
- ext_q_valid  output  1  registered valid.

Behaviour:
Interface rules:
- One clock (clk). Reset rst_n is asynchronous and active-low.
- sign_ex_out is purely combinational and unaffected by clk or rst_n.

Combinational result E, as a function of mode:
- mode 00: E = {16{in[15]}, in[15:0]}.
- mode 01: E = {16'h0000, in[15:0]}.
- mode 10: E = {24{in[7]}, in[7:0]}; in[15:8] ignored.
- mode 11: E = {24'h000000, in[7:0]}; in[15:8] ignored.

Shift and output:
- shift2=1: sign_ex_out = {E[29:0], 2'b00}. Top bits of E are discarded; no overflow flag.
- shift2=0: sign_ex_out = E.
- Output settles within the same cycle the inputs change; no latency.

Registered path:
- On rst_n low, immediately (asynchronously): ext_q = 32'h0000_0000, ext_q_valid = 0.
- Outputs hold these values while rst_n is low.
- On each rising clk with rst_n high:
  - ext_q_valid <= in_valid.
  - If in_valid=1: ext_q <= sign_ex_out.
  - If in_valid=0: ext_q holds its previous value.
- Latency is exactly 1 cycle. No backpressure; a new input may be accepted every cycle.
- Reset asserted mid-stream: the pending value is discarded and outputs clear at once.
- First edge after reset deassertion behaves normally.

Boundary cases:
- in = 16'h8000, mode 00 -> 32'hFFFF_8000.
- in = 16'h7FFF, mode 00 -> 32'h0000_7FFF.
- Byte modes with in[7]=1 and in[15:8]=0 sign-extend from bit 7, e.g. 16'h0080 mode 10 -> 32'hFFFF_FF80.

Test Plan:
- mode 00, shift2 0:
  - 16'hAAAA -> 32'hFFFF_AAAA
  - 16'h5555 -> 32'h0000_5555
  - 16'h0000 -> 32'h0000_0000
  - 16'hFFFF -> 32'hFFFF_FFFF
  - 16'h00FF -> 32'h0000_00FF
  - 16'hFF00 -> 32'hFFFF_FF00
- mode 01, in 16'hFF00 -> 32'h0000_FF00. mode 10, in 16'h00FF -> 32'hFFFF_FFFF. mode 11, in 16'hFF80 -> 32'h0000_0080.
- shift2 1, mode 00:
  - in 16'hFFFF -> 32'hFFFF_FFFC
  - in 16'h4000 -> 32'h0001_0000
  - in 16'h8000 -> 32'hFFFE_0000
- Registered path: in_valid 1, in 16'h8001, mode 00 at edge N -> ext_q = 32'hFFFF_8001 and ext_q_valid = 1 after edge N. in_valid 0 at edge N+1 -> ext_q unchanged, ext_q_valid = 0.
- Async reset: with ext_q nonzero, drop rst_n between clock edges -> ext_q = 0 and ext_q_valid = 0 immediately, without waiting for a clock edge. sign_ex_out still tracks the inputs.
- Back-to-back: in_valid held 1 with a new input every cycle -> ext_q follows the inputs with 1-cycle delay and no gaps.
